register_bus_sequencer: RTL

Bus initiator for the tau-processor register set. It accepts transfer commands over a valid/ready handshake and generates the per-register enable/read/write/reset strobes that register_N instances respond to. It muxes the source register's output onto the shared bus_value during the write phase, so one register's contents are copied into another, or one register is cleared. It sits between the control unit and the array of register_N instances.

---
 rtl/tau_bus_pkg.sv | 24 ++
 rtl/onehot_decoder.sv | 15 +
 rtl/register_bus_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/tau_bus_pkg.sv
// Shared types and helpers for the tau-processor register bus sequencer.
package tau_bus_pkg;

  // Command opcodes; 2'b10 and 2'b11 are reserved and rejected.
  typedef enum logic [1:0] {
    OP_MOVE  = 2'b00,
    OP_CLEAR = 2'b01
  } op_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    CLEAR,
    DONE
  } seq_state_t;

  // True for the opcodes the sequencer knows how to execute.
  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == OP_MOVE) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder with an enable; an out-of-range index gives all zeros.
module onehot_decoder #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot[gi] = en && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/register_bus_sequencer.sv
// Bus initiator that copies one register into another (MOVE) or clears one
// register (CLEAR) by sequencing per-register enable/read/write/reset strobes.
module register_bus_sequencer
  import tau_bus_pkg::*;
#(
  parameter int  NUM_REGS  = 4,
  parameter int  WORD_SIZE = 8,
  localparam int SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [SEL_W-1:0]              req_src,
  input  logic [SEL_W-1:0]              req_dst,
  input  logic [NUM_REGS*WORD_SIZE-1:0] reg_outputs,
  output logic [NUM_REGS-1:0]           reg_enable,
  output logic [NUM_REGS-1:0]           reg_read,
  output logic [NUM_REGS-1:0]           reg_write,
  output logic [NUM_REGS-1:0]           reg_reset,
  output logic [WORD_SIZE-1:0]          bus_value,
  output logic                          done,
  output logic                          error
);

  localparam logic [SEL_W:0] IDX_LIMIT = (SEL_W + 1)'(NUM_REGS);

  seq_state_t       state;
  logic [1:0]       op_reg;
  logic [SEL_W-1:0] src_reg;
  logic [SEL_W-1:0] dst_reg;
  logic             err_flag;

  logic             cmd_bad;
  logic [NUM_REGS-1:0] src_onehot;
  logic [NUM_REGS-1:0] dst_onehot;
  logic [WORD_SIZE-1:0] slices [NUM_REGS];

  // Classify the command on the request bus; only fields the op uses are range checked.
  always_comb begin
    cmd_bad = 1'b0;
    if (!is_valid_op(req_op)) begin
      cmd_bad = 1'b1;
    end else if ({1'b0, req_dst} >= IDX_LIMIT) begin
      cmd_bad = 1'b1;
    end else if (req_op == OP_MOVE) begin
      cmd_bad = ({1'b0, req_src} >= IDX_LIMIT) || (req_src == req_dst);
    end
  end

  // Sequencer FSM: accept in IDLE, then walk READ/WRITE or CLEAR, finishing in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_reg   <= 2'b00;
      src_reg  <= '0;
      dst_reg  <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_reg  <= req_op;
            src_reg <= req_src;
            dst_reg <= req_dst;
            if (cmd_bad) begin
              err_flag <= 1'b1;
              state    <= DONE;
            end else if (req_op == OP_MOVE) begin
              state <= READ;
            end else begin
              state <= CLEAR;
            end
          end
        end
        READ:    state <= (op_reg == OP_MOVE) ? WRITE : DONE;
        WRITE:   state <= DONE;
        CLEAR:   state <= DONE;
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Source strobes only in READ; destination strobes in WRITE or CLEAR.
  onehot_decoder #(.N(NUM_REGS), .SEL_W(SEL_W)) u_src_dec (
    .en     (state == READ),
    .sel    (src_reg),
    .onehot (src_onehot)
  );

  onehot_decoder #(.N(NUM_REGS), .SEL_W(SEL_W)) u_dst_dec (
    .en     ((state == WRITE) || (state == CLEAR)),
    .sel    (dst_reg),
    .onehot (dst_onehot)
  );

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slice
    assign slices[gi] = reg_outputs[gi*WORD_SIZE +: WORD_SIZE];
  end

  // Ready is forced low while reset is held so nothing is offered during reset.
  assign req_ready  = (state == IDLE) && !reset;
  assign reg_read   = src_onehot;
  assign reg_write  = (state == WRITE) ? dst_onehot : '0;
  assign reg_reset  = (state == CLEAR) ? dst_onehot : '0;
  assign reg_enable = src_onehot | reg_write;
  assign bus_value  = (state == WRITE) ? slices[src_reg] : '0;
  assign done       = (state == DONE);
  assign error      = (state == DONE) && err_flag;

endmodule
